// File: rtl/parking_pkg.sv
// parking_pkg: shared types and constants for the car-parking gate scheduler.
//   park_state_t      - scheduler FSM states
//   PW_WIDTH          - per-lane password width
//   VEHICLE_NO_WIDTH  - plate number width, reserved for plate logging
//   max_int           - elaboration-time helper for sizing counters
package parking_pkg;

  localparam int PW_WIDTH         = 4;
  localparam int VEHICLE_NO_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_CHECK,
    ST_OPEN,
    ST_REJECT
  } park_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_gate_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over N requesters.
//   req   - request vector
//   last  - index of the previous winner (lowest priority this round)
//   grant - one-hot winner, 0 when no request
//   idx   - winner index, 0 when no request
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int pos;

  // Walk offsets from farthest to nearest so the nearest requester after
  // 'last' is the final (winning) assignment.
  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = 0;
    for (int k = N; k >= 1; k--) begin
      pos = int'(last) + k;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        grant = N'(1) << pos;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler: shares one password checker / entry gate among
// NUM_LANES entry lanes, round-robin, only while the lot has free slots.
//   clk, reset            - clock, synchronous active-high reset
//   lane_req              - per-lane vehicle present (level)
//   lane_pw_entered       - per-lane password valid (level)
//   lane_password         - per-lane passwords, lane i at [4i+3:4i]
//   exit_req              - one-cycle pulse, a car left the lot
//   lane_grant            - one-hot checker owner, 0 when idle
//   chk_vehicle_present   - to checker, any lane granted
//   chk_password_entered  - granted lane's pw_entered while in GRANT
//   chk_password          - granted lane's password, 0 when idle
//   chk_result_valid/ok   - checker verdict
//   gate_open             - entry gate drive
//   lane_done/lane_reject - one-cycle per-lane outcome pulses
//   free_slots, lot_full  - occupancy
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_LANES        = 2,
  parameter int NUM_SLOTS        = 8,
  parameter int PW_TIMEOUT       = 16,
  parameter int GATE_OPEN_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_LANES-1:0]              lane_req,
  input  logic [NUM_LANES-1:0]              lane_pw_entered,
  input  logic [PW_WIDTH*NUM_LANES-1:0]     lane_password,
  input  logic                              exit_req,
  output logic [NUM_LANES-1:0]              lane_grant,
  output logic                              chk_vehicle_present,
  output logic                              chk_password_entered,
  output logic [PW_WIDTH-1:0]               chk_password,
  input  logic                              chk_result_valid,
  input  logic                              chk_result_ok,
  output logic                              gate_open,
  output logic [NUM_LANES-1:0]              lane_done,
  output logic [NUM_LANES-1:0]              lane_reject,
  output logic [$clog2(NUM_SLOTS+1)-1:0]    free_slots,
  output logic                              lot_full
);

  localparam int IW = $clog2(NUM_LANES);
  localparam int FW = $clog2(NUM_SLOTS+1);
  // One timer serves both the entry timeout and the gate-open window.
  localparam int TW = $clog2(max_int(PW_TIMEOUT, GATE_OPEN_CYCLES) + 1);

  localparam logic [FW-1:0] SLOTS_MAX = FW'(NUM_SLOTS);
  localparam logic [TW-1:0] PW_LAST   = TW'(PW_TIMEOUT - 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(GATE_OPEN_CYCLES - 1);

  park_state_t state, state_d;
  logic [NUM_LANES-1:0] grant_q, grant_d, arb_grant;
  logic [IW-1:0]        idx_q, idx_d, last_q, last_d, arb_idx;
  logic [TW-1:0]        tmr;
  logic [FW-1:0]        free_q;
  logic                 admit;

  logic [NUM_LANES-1:0][PW_WIDTH-1:0] pw_arr;
  assign pw_arr = lane_password;

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .req   (lane_req),
    .last  (last_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d              = state;
    grant_d              = grant_q;
    idx_d                = idx_q;
    last_d               = last_q;
    admit                = 1'b0;
    lane_grant           = '0;
    chk_password_entered = 1'b0;
    chk_password         = '0;
    gate_open            = 1'b0;
    lane_done            = '0;
    lane_reject          = '0;
    unique case (state)
      ST_IDLE: begin
        // lot_full is registered, so a same-cycle exit cannot sway this pick
        if (|lane_req && !lot_full) begin
          state_d = ST_GRANT;
          grant_d = arb_grant;
          idx_d   = arb_idx;
          last_d  = arb_idx;
        end
      end
      ST_GRANT: begin
        lane_grant           = grant_q;
        chk_password         = pw_arr[idx_q];
        chk_password_entered = lane_pw_entered[idx_q];
        if (lane_pw_entered[idx_q])  state_d = ST_CHECK;
        else if (!lane_req[idx_q])   state_d = ST_IDLE;
        else if (tmr == PW_LAST)     state_d = ST_REJECT;
      end
      ST_CHECK: begin
        lane_grant   = grant_q;
        chk_password = pw_arr[idx_q];
        if (chk_result_valid) begin
          if (chk_result_ok) begin
            state_d = ST_OPEN;
            admit   = 1'b1;
          end else begin
            state_d = ST_REJECT;
          end
        end else if (tmr == PW_LAST) begin
          state_d = ST_REJECT;
        end
      end
      ST_OPEN: begin
        lane_grant   = grant_q;
        chk_password = pw_arr[idx_q];
        gate_open    = 1'b1;
        if (tmr == OPEN_LAST) begin
          lane_done = grant_q;
          state_d   = ST_IDLE;
        end
      end
      ST_REJECT: begin
        lane_grant   = grant_q;
        chk_password = pw_arr[idx_q];
        lane_reject  = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign chk_vehicle_present = |lane_grant;
  assign free_slots          = free_q;
  assign lot_full            = (free_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NUM_LANES - 1);
      tmr     <= '0;
      free_q  <= SLOTS_MAX;
    end else begin
      state   <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      // timer counts cycles spent in the current state
      tmr     <= (state_d != state || state == ST_IDLE) ? '0 : tmr + 1'b1;
      if (admit && !exit_req)
        free_q <= free_q - 1'b1;
      else if (exit_req && !admit && free_q != SLOTS_MAX)
        free_q <= free_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
module tb_parking_gate_scheduler;
  localparam int NL = 2;
  localparam int NS = 8;
  localparam int PT = 16;
  localparam int GC = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NL-1:0]   lane_req, lane_pw_entered, lane_grant, lane_done, lane_reject;
  logic [4*NL-1:0] lane_password;
  logic            exit_req, chk_vehicle_present, chk_password_entered;
  logic [3:0]      chk_password;
  logic            chk_result_valid, chk_result_ok, gate_open, lot_full;
  logic [3:0]      free_slots;

  int n_chk = 0;
  int n_fail = 0;
  int exp_free, exp_last;

  always #5 clk = ~clk;

  parking_gate_scheduler #(
    .NUM_LANES(NL), .NUM_SLOTS(NS), .PW_TIMEOUT(PT), .GATE_OPEN_CYCLES(GC)
  ) dut (
    .clk(clk), .reset(reset), .lane_req(lane_req), .lane_pw_entered(lane_pw_entered),
    .lane_password(lane_password), .exit_req(exit_req), .lane_grant(lane_grant),
    .chk_vehicle_present(chk_vehicle_present), .chk_password_entered(chk_password_entered),
    .chk_password(chk_password), .chk_result_valid(chk_result_valid),
    .chk_result_ok(chk_result_ok), .gate_open(gate_open), .lane_done(lane_done),
    .lane_reject(lane_reject), .free_slots(free_slots), .lot_full(lot_full)
  );

  // Round-robin rule: first requester after the last winner, wrapping.
  function automatic int rr_pick(input logic [NL-1:0] req, input int last);
    for (int k = 1; k <= NL; k++)
      if (req[(last + k) % NL]) return (last + k) % NL;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lane_req = '0; lane_pw_entered = '0; exit_req = 1'b0;
    chk_result_valid = 1'b0; chk_result_ok = 1'b0;
  endtask

  task automatic admit_lane(input int lane, output bit done);
    done = 1'b0;
    lane_req[lane] = 1'b1; lane_pw_entered[lane] = 1'b1;
    chk_result_valid = 1'b1; chk_result_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (lane_done[lane]) begin done = 1'b1; break; end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs(); lane_password = '0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0; exp_free = NS; exp_last = NL - 1;
    n_chk++; if (lane_grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0", lane_grant); end
    n_chk++; if ({chk_vehicle_present, chk_password_entered, chk_password} !== 6'b0) begin n_fail++; $display("FAIL reset_chk: got %b%b%h expected 0", chk_vehicle_present, chk_password_entered, chk_password); end
    n_chk++; if ({gate_open, lane_done, lane_reject} !== '0) begin n_fail++; $display("FAIL reset_pulses: got %b %b %b expected 0", gate_open, lane_done, lane_reject); end
    n_chk++; if (free_slots !== 4'(NS) || lot_full !== 1'b0) begin n_fail++; $display("FAIL reset_occ: got %0d/%b expected %0d/0", free_slots, lot_full, NS); end
  endtask

  task automatic test_single_lane();
    int gates, dones, done_at;
    lane_password = {4'($urandom), 4'b0011};
    lane_req = 2'b01;
    tick();
    exp_last = 0;
    n_chk++; if (lane_grant !== 2'b01 || chk_vehicle_present !== 1'b1) begin n_fail++; $display("FAIL single_grant: got %b/%b expected 01/1", lane_grant, chk_vehicle_present); end
    n_chk++; if (chk_password !== 4'b0011) begin n_fail++; $display("FAIL single_pw: got %b expected 0011", chk_password); end
    n_chk++; if (chk_password_entered !== 1'b0) begin n_fail++; $display("FAIL single_pwe_low: got %b expected 0", chk_password_entered); end
    lane_pw_entered = 2'b01;
    #1;
    n_chk++; if (chk_password_entered !== 1'b1) begin n_fail++; $display("FAIL single_pwe_comb: got %b expected 1", chk_password_entered); end
    tick();
    n_chk++; if (chk_password_entered !== 1'b0) begin n_fail++; $display("FAIL single_pwe_gated: got %b expected 0", chk_password_entered); end
    tick();
    chk_result_valid = 1'b1; chk_result_ok = 1'b1;
    tick();
    idle_inputs();
    exp_free--;
    n_chk++; if (free_slots !== 4'(exp_free)) begin n_fail++; $display("FAIL single_free: got %0d expected %0d", free_slots, exp_free); end
    gates = 0; dones = 0; done_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (gate_open) gates++;
      if (lane_done !== 2'b00) begin dones++; done_at = i; if (lane_done !== 2'b01) dones += 10; end
      tick();
    end
    n_chk++; if (gates !== GC) begin n_fail++; $display("FAIL single_gate_len: got %0d expected %0d", gates, GC); end
    n_chk++; if (dones !== 1 || done_at !== GC - 1) begin n_fail++; $display("FAIL single_done: got cnt %0d at %0d expected 1 at %0d", dones, done_at, GC - 1); end
  endtask

  task automatic test_round_robin();
    int grants, admits, w;
    logic [NL-1:0] prev;
    grants = 0; admits = 0; prev = '0;
    lane_req = 2'b11; lane_pw_entered = 2'b11; chk_result_valid = 1'b1; chk_result_ok = 1'b1;
    for (int c = 0; c < 200 && admits < 4; c++) begin
      tick();
      if (lane_grant !== '0 && prev === '0) begin
        w = rr_pick(2'b11, exp_last);
        n_chk++; if (lane_grant !== NL'(1) << w) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", grants, lane_grant, NL'(1) << w); end
        exp_last = w; grants++;
      end
      if (lane_done !== '0) begin
        admits++; exp_free--;
        if (admits == 4) idle_inputs();
      end
      prev = lane_grant;
    end
    tick();
    n_chk++; if (grants !== 4 || admits !== 4) begin n_fail++; $display("FAIL rr_count: got %0d grants %0d admits expected 4/4", grants, admits); end
    n_chk++; if (free_slots !== 4'(exp_free)) begin n_fail++; $display("FAIL rr_free: got %0d expected %0d", free_slots, exp_free); end
  endtask

  task automatic test_lot_full();
    bit done;
    int lane, seen, pulses;
    lane = 0;
    while (exp_free > 0) begin
      admit_lane(lane, done);
      n_chk++; if (!done) begin n_fail++; $display("FAIL full_admit: lane %0d got no done expected done", lane); end
      exp_free--; exp_last = lane; lane = 1 - lane;
    end
    n_chk++; if (lot_full !== 1'b1 || free_slots !== 4'd0) begin n_fail++; $display("FAIL full_flag: got %b/%0d expected 1/0", lot_full, free_slots); end
    lane_req = 2'b01; seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (lane_grant !== '0) seen++; end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL full_held: got %0d grant cycles expected 0", seen); end
    exit_req = 1'b1; tick(); exit_req = 1'b0;
    exp_free = 1;
    n_chk++; if (free_slots !== 4'd1 || lot_full !== 1'b0) begin n_fail++; $display("FAIL full_exit: got %0d/%b expected 1/0", free_slots, lot_full); end
    n_chk++; if (lane_grant !== '0) begin n_fail++; $display("FAIL full_same_cycle: got %b expected 0", lane_grant); end
    tick();
    n_chk++; if (lane_grant !== NL'(1) << rr_pick(2'b01, exp_last)) begin n_fail++; $display("FAIL full_grant: got %b expected 01", lane_grant); end
    exp_last = 0;
    tick(); tick();
    lane_req = '0; pulses = 0;
    tick();
    n_chk++; if (lane_grant !== '0) begin n_fail++; $display("FAIL drop_idle: got %b expected 0", lane_grant); end
    for (int i = 0; i < 20; i++) begin if (lane_done !== '0 || lane_reject !== '0 || gate_open) pulses++; tick(); end
    n_chk++; if (pulses !== 0 || free_slots !== 4'(exp_free)) begin n_fail++; $display("FAIL drop_silent: got %0d pulses free %0d expected 0/%0d", pulses, free_slots, exp_free); end
  endtask

  task automatic test_reject();
    int rejs, gates, others;
    lane_req = 2'b10; lane_pw_entered = 2'b10;
    tick();
    exp_last = rr_pick(2'b10, exp_last);
    n_chk++; if (lane_grant !== NL'(1) << exp_last) begin n_fail++; $display("FAIL rej_grant: got %b expected 10", lane_grant); end
    tick();
    chk_result_valid = 1'b1; chk_result_ok = 1'b0;
    tick();
    idle_inputs();
    rejs = 0; gates = 0; others = 0;
    for (int i = 0; i < 10; i++) begin
      if (lane_reject === 2'b10) rejs++; else if (lane_reject !== '0) others++;
      if (gate_open || lane_done !== '0) gates++;
      tick();
    end
    n_chk++; if (rejs !== 1 || others !== 0) begin n_fail++; $display("FAIL rej_pulse: got %0d/%0d expected 1/0", rejs, others); end
    n_chk++; if (gates !== 0) begin n_fail++; $display("FAIL rej_gate: got %0d expected 0", gates); end
    n_chk++; if (free_slots !== 4'(exp_free)) begin n_fail++; $display("FAIL rej_free: got %0d expected %0d", free_slots, exp_free); end
  endtask

  task automatic test_timeout();
    int lane, cnt;
    logic [NL-1:0] rv;
    lane = $urandom_range(0, NL - 1);
    lane_req = NL'(1) << lane;
    tick();
    exp_last = lane;
    cnt = 0; rv = '0;
    for (int c = 0; c < PT + 10; c++) begin
      tick(); cnt++;
      if (lane_reject !== '0) begin rv = lane_reject; break; end
    end
    idle_inputs(); tick();
    n_chk++; if (cnt !== PT) begin n_fail++; $display("FAIL timeout_len: got %0d expected %0d", cnt, PT); end
    n_chk++; if (rv !== NL'(1) << lane) begin n_fail++; $display("FAIL timeout_lane: got %b expected %b", rv, NL'(1) << lane); end
  endtask

  task automatic test_admit_exit();
    bit done;
    lane_req = 2'b01; lane_pw_entered = 2'b01;
    tick(); exp_last = 0;
    tick();
    lane_req = '0;
    tick();
    n_chk++; if (lane_grant !== 2'b01) begin n_fail++; $display("FAIL check_drop_ignored: got %b expected 01", lane_grant); end
    chk_result_valid = 1'b1; chk_result_ok = 1'b1; exit_req = 1'b1;
    tick();
    idle_inputs();
    n_chk++; if (free_slots !== 4'(exp_free) || gate_open !== 1'b1) begin n_fail++; $display("FAIL admit_exit: got %0d/%b expected %0d/1", free_slots, gate_open, exp_free); end
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin if (lane_done === 2'b01) done = 1'b1; tick(); end
    n_chk++; if (!done) begin n_fail++; $display("FAIL admit_exit_done: got none expected done"); end
    while (exp_free < NS) begin exit_req = 1'b1; tick(); exit_req = 1'b0; exp_free++; end
    n_chk++; if (free_slots !== 4'(NS)) begin n_fail++; $display("FAIL exit_restore: got %0d expected %0d", free_slots, NS); end
    exit_req = 1'b1; tick(); exit_req = 1'b0;
    n_chk++; if (free_slots !== 4'(NS)) begin n_fail++; $display("FAIL exit_sat: got %0d expected %0d", free_slots, NS); end
  endtask

  task automatic test_reset_mid();
    bit open;
    lane_req = 2'b01; lane_pw_entered = 2'b01; chk_result_valid = 1'b1; chk_result_ok = 1'b1;
    open = 1'b0;
    for (int c = 0; c < 10 && !open; c++) begin tick(); if (gate_open) open = 1'b1; end
    n_chk++; if (!open) begin n_fail++; $display("FAIL mid_reach_open: got closed expected open"); end
    reset = 1'b1;
    tick();
    idle_inputs(); reset = 1'b0; exp_free = NS; exp_last = NL - 1;
    n_chk++; if ({lane_grant, gate_open, lane_done, lane_reject, chk_vehicle_present, chk_password_entered, chk_password} !== '0) begin n_fail++; $display("FAIL mid_reset_out: got %b %b %b %b %h expected 0", lane_grant, gate_open, lane_done, lane_reject, chk_password); end
    n_chk++; if (free_slots !== 4'(NS) || lot_full !== 1'b0) begin n_fail++; $display("FAIL mid_reset_occ: got %0d/%b expected %0d/0", free_slots, lot_full, NS); end
    lane_req = 2'b11;
    tick();
    n_chk++; if (lane_grant !== 2'b01) begin n_fail++; $display("FAIL mid_first_lane: got %b expected 01", lane_grant); end
    exp_last = 0;
    lane_req = '0; tick(); tick();
  endtask

  task automatic test_random();
    logic [NL-1:0] req, eg, rv;
    logic [4*NL-1:0] pw;
    logic [3:0] epw;
    int w, outcome, cnt, gates, dones, rejs, done_at;
    bit got;
    for (int t = 0; t < 25; t++) begin
      if (exp_free == 0) begin exit_req = 1'b1; tick(); exit_req = 1'b0; exp_free++; end
      req = NL'($urandom_range(1, (1 << NL) - 1));
      pw = 8'($urandom);
      lane_password = pw; lane_req = req;
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin tick(); if (lane_grant !== '0) got = 1'b1; end
      w = rr_pick(req, exp_last); exp_last = w;
      eg = NL'(1) << w; epw = pw[w*4 +: 4];
      n_chk++; if (lane_grant !== eg) begin n_fail++; $display("FAIL rnd_grant%0d: got %b expected %b", t, lane_grant, eg); end
      n_chk++; if (chk_password !== epw) begin n_fail++; $display("FAIL rnd_pw%0d: got %h expected %h", t, chk_password, epw); end
      if (!got) begin idle_inputs(); tick(); continue; end
      outcome = $urandom_range(0, 3);
      if (outcome != 3) begin
        repeat ($urandom_range(0, 3)) tick();
        lane_pw_entered[w] = 1'b1;
        tick();
        repeat ($urandom_range(0, 3)) tick();
        chk_result_valid = 1'b1; chk_result_ok = (outcome < 2);
        tick();
        idle_inputs();
        gates = 0; dones = 0; rejs = 0; done_at = -1;
        for (int i = 0; i < 10; i++) begin
          if (gate_open) gates++;
          if (lane_done === eg) begin dones++; done_at = i; end else if (lane_done !== '0) dones += 10;
          if (lane_reject === eg) rejs++; else if (lane_reject !== '0) rejs += 10;
          tick();
        end
        if (outcome < 2) begin
          exp_free--;
          n_chk++; if (gates !== GC || dones !== 1 || done_at !== GC - 1 || rejs !== 0) begin n_fail++; $display("FAIL rnd_admit%0d: got gates %0d done %0d@%0d rej %0d expected %0d 1@%0d 0", t, gates, dones, done_at, rejs, GC, GC - 1); end
        end else begin
          n_chk++; if (gates !== 0 || dones !== 0 || rejs !== 1) begin n_fail++; $display("FAIL rnd_reject%0d: got gates %0d done %0d rej %0d expected 0 0 1", t, gates, dones, rejs); end
        end
      end else begin
        cnt = 0; rv = '0;
        for (int c = 0; c < PT + 10; c++) begin
          tick(); cnt++;
          if (lane_reject !== '0) begin rv = lane_reject; break; end
        end
        idle_inputs(); tick();
        n_chk++; if (cnt !== PT || rv !== eg) begin n_fail++; $display("FAIL rnd_timeout%0d: got %0d cycles lane %b expected %0d lane %b", t, cnt, rv, PT, eg); end
      end
      n_chk++; if (free_slots !== 4'(exp_free)) begin n_fail++; $display("FAIL rnd_free%0d: got %0d expected %0d", t, free_slots, exp_free); end
      if ($urandom_range(0, 2) == 0) begin
        exit_req = 1'b1; tick(); exit_req = 1'b0;
        if (exp_free < NS) exp_free++;
        n_chk++; if (free_slots !== 4'(exp_free)) begin n_fail++; $display("FAIL rnd_exit%0d: got %0d expected %0d", t, free_slots, exp_free); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_lane();
    test_round_robin();
    test_lot_full();
    test_reject();
    test_timeout();
    test_admit_exit();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
